// File: rtl/dpll_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dpll_pkg
// Purpose  : Shared types and constants for the DPLL observability blocks:
//            frequency-monitor FSM state encoding, default gate/target
//            settings and a constant-evaluable ceil(log2) helper.
// Revision : 1.0 - initial release
// ============================================================================
package dpll_pkg;

  // Frequency-monitor FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } mon_state_t;

  // Default monitor settings: 250 DPLL edges expected per 1000 clk window.
  localparam int DEF_GATE_CYCLES  = 1000;
  localparam int DEF_CNT_W        = 16;
  localparam int DEF_TARGET_COUNT = 250;
  localparam int DEF_TOLERANCE    = 2;
  localparam int DEF_LOCK_WINDOWS = 4;

  // ceil(log2(value)), never less than 1 so it can size a counter directly.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage : dpll_pkg
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_det
// Purpose  : Brings an asynchronous level into the clk domain through a
//            two-flop synchroniser, keeps one history flop and emits a
//            single-cycle pulse for every synchronised rising edge.
//            A rise on i_async appears on o_rise 3 clk edges later
//            (counted by logic registering o_rise on the third edge).
// Ports    : clk      in  system clock
//            rst_n    in  asynchronous active-low reset
//            i_async  in  level asynchronous to clk
//            o_rise   out 1-cycle rising-edge pulse
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_hist <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_hist <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_hist;

endmodule : sync_edge_det
`default_nettype wire

// File: rtl/gclk_freq_monitor.sv
`default_nettype none
// ============================================================================
// Module   : gclk_freq_monitor
// Purpose  : Counts rising edges of the globally buffered DPLL output over a
//            fixed gate window of clk cycles, reports the count each window,
//            flags whether it is within TARGET_COUNT +/- TOLERANCE and raises
//            locked after LOCK_WINDOWS consecutive in-range windows.
// Ports    : clk          in  system clock
//            rst_n        in  asynchronous active-low reset
//            sig_in       in  buffered DPLL output, asynchronous to clk
//            enable       in  1 = measure continuously, 0 = idle/abort
//            count_out    out edge count of the last completed window
//            count_valid  out 1-cycle pulse when count_out/in_range update
//            in_range     out last window within target tolerance
//            locked       out LOCK_WINDOWS consecutive in-range windows seen
//            overflow     out last window's edge counter saturated
// Revision : 1.0 - initial release
// ============================================================================
module gclk_freq_monitor
  import dpll_pkg::*;
#(
  parameter int GATE_CYCLES  = DEF_GATE_CYCLES,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int TARGET_COUNT = DEF_TARGET_COUNT,
  parameter int TOLERANCE    = DEF_TOLERANCE,
  parameter int LOCK_WINDOWS = DEF_LOCK_WINDOWS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             in_range,
  output logic             locked,
  output logic             overflow
);

  localparam int C_GATE_W   = clog2(GATE_CYCLES);
  localparam int C_STREAK_W = clog2(LOCK_WINDOWS + 1);

  localparam logic [C_GATE_W-1:0]   C_GATE_LAST = C_GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      C_CNT_MAX   = '1;
  // Range compare runs one bit wider than the counter so targets above the
  // counter range and the subtraction itself never wrap.
  localparam logic [CNT_W:0]        C_TARGET    = (CNT_W + 1)'(TARGET_COUNT);
  localparam logic [CNT_W:0]        C_TOL       = (CNT_W + 1)'(TOLERANCE);
  localparam logic [C_STREAK_W-1:0] C_LOCK      = C_STREAK_W'(LOCK_WINDOWS);

  mon_state_t            r_state;
  mon_state_t            w_state_next;
  logic                  w_report;
  logic                  w_drop_lock;

  logic [C_GATE_W-1:0]   r_gate_cnt;
  logic [CNT_W-1:0]      r_edge_cnt;
  logic                  r_win_ovf;
  logic [C_STREAK_W-1:0] r_streak;

  logic                  w_rise;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  w_ovf_inc;
  logic [CNT_W:0]        w_cnt_ext;
  logic [CNT_W:0]        w_diff;
  logic                  w_in_range;
  logic [C_STREAK_W-1:0] w_streak_inc;

  // --------------------------------------------------------------------------
  // Input synchroniser and edge detector
  // --------------------------------------------------------------------------
  sync_edge_det u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (sig_in),
    .o_rise  (w_rise)
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Dropping enable always wins over completing a window, so a window that
  // is aborted on its last cycle never produces a report.
  always_comb begin
    w_state_next = r_state;
    w_report     = 1'b0;
    w_drop_lock  = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_next = MEASURE;
        end
      end
      MEASURE: begin
        if (!enable) begin
          w_state_next = IDLE;
          w_drop_lock  = 1'b1;
        end else if (r_gate_cnt == C_GATE_LAST) begin
          w_state_next = REPORT;
          w_report     = 1'b1;
        end
      end
      REPORT: begin
        if (enable) begin
          w_state_next = MEASURE;
        end else begin
          w_state_next = IDLE;
          w_drop_lock  = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Edge counter next value: saturating, with sticky overflow. Used both for
  // the running count and for the final value that includes an edge on the
  // gate's last cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_cnt_inc = r_edge_cnt;
    w_ovf_inc = r_win_ovf;
    if (w_rise) begin
      if (r_edge_cnt == C_CNT_MAX) begin
        w_ovf_inc = 1'b1;
      end else begin
        w_cnt_inc = r_edge_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Gate and edge counters
  // --------------------------------------------------------------------------
  // The counters are cleared on the edge that enters REPORT; the REPORT
  // cycle's own edge detect then seeds the next window so no edge is lost
  // between back-to-back windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_win_ovf  <= 1'b0;
    end else begin
      case (r_state)
        MEASURE: begin
          if (r_gate_cnt == C_GATE_LAST) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_win_ovf  <= 1'b0;
          end else begin
            r_gate_cnt <= r_gate_cnt + 1'b1;
            r_edge_cnt <= w_cnt_inc;
            r_win_ovf  <= w_ovf_inc;
          end
        end
        REPORT: begin
          r_gate_cnt <= '0;
          r_edge_cnt <= w_cnt_inc;
          r_win_ovf  <= w_ovf_inc;
        end
        default: begin
          r_gate_cnt <= '0;
          r_edge_cnt <= '0;
          r_win_ovf  <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Range compare and lock streak
  // --------------------------------------------------------------------------
  assign w_cnt_ext    = {1'b0, w_cnt_inc};
  assign w_diff       = (w_cnt_ext >= C_TARGET) ? (w_cnt_ext - C_TARGET)
                                                : (C_TARGET - w_cnt_ext);
  assign w_in_range   = ~w_ovf_inc & (w_diff <= C_TOL);
  assign w_streak_inc = (r_streak >= C_LOCK) ? C_LOCK : (r_streak + 1'b1);

  // Report registers load on the edge entering REPORT so they are already
  // valid while count_valid is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_out   <= '0;
      count_valid <= 1'b0;
      in_range    <= 1'b0;
      overflow    <= 1'b0;
      locked      <= 1'b0;
      r_streak    <= '0;
    end else begin
      count_valid <= w_report;
      if (w_report) begin
        count_out <= w_cnt_inc;
        overflow  <= w_ovf_inc;
        in_range  <= w_in_range;
        if (w_in_range) begin
          r_streak <= w_streak_inc;
          locked   <= (w_streak_inc >= C_LOCK);
        end else begin
          r_streak <= '0;
          locked   <= 1'b0;
        end
      end else if (w_drop_lock) begin
        r_streak <= '0;
        locked   <= 1'b0;
      end
    end
  end

endmodule : gclk_freq_monitor
`default_nettype wire

// File: tb/tb_gclk_freq_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_gclk_freq_monitor
// Purpose  : Self-checking bench for gclk_freq_monitor (GATE_CYCLES=100,
//            TARGET_COUNT=25, TOLERANCE=1, LOCK_WINDOWS=3). A second instance
//            with CNT_W=4 covers counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gclk_freq_monitor;

  logic       clk;
  logic       rst_n;
  logic       sig_in;
  logic       enable;
  logic [7:0] count_out;
  logic       count_valid;
  logic       in_range;
  logic       locked;
  logic       overflow;

  logic       sig_in2;
  logic       enable2;
  logic [3:0] count_out2;
  logic       count_valid2;
  logic       in_range2;
  logic       locked2;
  logic       overflow2;

  // n = number of clk rising edges so far; sig_in is recomputed 1 ns after
  // each edge from (per, base): rising at base, base+per, ...
  int n;
  int per;
  int base;
  int e_ref;
  bit sched_on;

  int checks;
  int errors;

  typedef struct {
    int exp_count;
    int exp_in;
    int exp_lock;
  } win_t;

  win_t tbl1[7];
  win_t tbl2[3];

  gclk_freq_monitor #(
    .GATE_CYCLES (100), .CNT_W (8), .TARGET_COUNT (25),
    .TOLERANCE (1), .LOCK_WINDOWS (3)
  ) dut (
    .clk (clk), .rst_n (rst_n), .sig_in (sig_in), .enable (enable),
    .count_out (count_out), .count_valid (count_valid),
    .in_range (in_range), .locked (locked), .overflow (overflow)
  );

  gclk_freq_monitor #(
    .GATE_CYCLES (100), .CNT_W (4), .TARGET_COUNT (25),
    .TOLERANCE (1), .LOCK_WINDOWS (3)
  ) dut_sat (
    .clk (clk), .rst_n (rst_n), .sig_in (sig_in2), .enable (enable2),
    .count_out (count_out2), .count_valid (count_valid2),
    .in_range (in_range2), .locked (locked2), .overflow (overflow2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stimulus driver. Relative to e_ref: at +300 switch to period 5 (first
  // rise +302), at +401 back to period 4 (first rise +405).
  initial begin
    n        = 0;
    per      = 0;
    base     = 0;
    e_ref    = 0;
    sched_on = 1'b0;
    sig_in   = 1'b0;
    sig_in2  = 1'b0;
    forever begin
      @(posedge clk);
      n = n + 1;
      #1;
      if (sched_on) begin
        if (n - e_ref == 300) begin
          per  = 5;
          base = e_ref + 302;
        end
        if (n - e_ref == 401) begin
          per  = 4;
          base = e_ref + 405;
        end
      end
      sig_in  = (per != 0) && (n >= base) && (((n - base) % per) < (per / 2));
      sig_in2 = ((n % 2) == 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Returns the edge index at which count_valid is seen high, or -1.
  task automatic wait_pulse(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (count_valid === 1'b1) begin
        at = n;
        break;
      end
    end
    if (at < 0) chk("pulse_timeout", 0, 1);
  endtask

  task automatic chk_window(input int at, input int exp_at, input win_t w);
    chk("pulse_time", at, exp_at);
    chk("count_out", int'(count_out), w.exp_count);
    chk("in_range", int'(in_range), w.exp_in);
    chk("locked", int'(locked), w.exp_lock);
    chk("overflow", int'(overflow), 0);
  endtask

  initial begin
    int e0;
    int e1;
    int e2;
    int at;
    bit seen;

    checks = 0;
    errors = 0;

    // Period 4 then period 5 then period 4 again (lock, unlock, relock).
    tbl1[0] = '{exp_count: 25, exp_in: 1, exp_lock: 0};
    tbl1[1] = '{exp_count: 25, exp_in: 1, exp_lock: 0};
    tbl1[2] = '{exp_count: 25, exp_in: 1, exp_lock: 1};
    tbl1[3] = '{exp_count: 20, exp_in: 0, exp_lock: 0};
    tbl1[4] = '{exp_count: 25, exp_in: 1, exp_lock: 0};
    tbl1[5] = '{exp_count: 25, exp_in: 1, exp_lock: 0};
    tbl1[6] = '{exp_count: 25, exp_in: 1, exp_lock: 1};
    // Window 2 gets one rise on the previous REPORT cycle and one on its
    // final gate cycle -> 26.
    tbl2[0] = '{exp_count: 25, exp_in: 1, exp_lock: 0};
    tbl2[1] = '{exp_count: 26, exp_in: 1, exp_lock: 0};
    tbl2[2] = '{exp_count: 25, exp_in: 1, exp_lock: 1};

    rst_n   = 1'b0;
    enable  = 1'b0;
    enable2 = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_count_out", int'(count_out), 0);
    chk("rst_count_valid", int'(count_valid), 0);
    chk("rst_in_range", int'(in_range), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_count_out2", int'(count_out2), 0);
    #3;
    rst_n = 1'b1;

    // Continuous measurement, lock, unlock, relock
    repeat (2) @(posedge clk);
    #2;
    e0       = n;
    e_ref    = n;
    per      = 4;
    base     = n + 2;
    sched_on = 1'b1;
    enable   = 1'b1;
    enable2  = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      wait_pulse(at);
      chk_window(at, e0 + 101 * k, tbl1[k-1]);
      if (k == 1) begin
        chk("sat_valid", int'(count_valid2), 1);
        chk("sat_count", int'(count_out2), 15);
        chk("sat_overflow", int'(overflow2), 1);
        chk("sat_in_range", int'(in_range2), 0);
      end
      @(negedge clk);
      chk("pulse_width", int'(count_valid), 0);
    end

    // Abort at gate cycle 50 of window 8
    do begin
      @(posedge clk);
      #2;
    end while (n < e0 + 758);
    chk("lock_before_abort", int'(locked), 1);
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_valid", int'(count_valid), 0);
    chk("abort_locked", int'(locked), 0);
    chk("abort_count_hold", int'(count_out), 25);
    chk("abort_in_range_hold", int'(in_range), 1);
    chk("abort_overflow_hold", int'(overflow), 0);
    seen = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (count_valid === 1'b1) seen = 1'b1;
    end
    chk("idle_no_valid", int'(seen), 0);
    chk("idle_locked", int'(locked), 0);

    // Re-enable so that rises land on window 2's first and last counted cycle
    do begin
      @(posedge clk);
      #2;
    end while (((n - e0) % 4) != 2);
    e1     = n;
    enable = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      wait_pulse(at);
      chk_window(at, e1 + 101 * k, tbl2[k-1]);
      @(negedge clk);
      chk("pulse_width2", int'(count_valid), 0);
    end

    // Asynchronous reset mid-window
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    per   = 0;
    #1;
    chk("arst_count_out", int'(count_out), 0);
    chk("arst_count_valid", int'(count_valid), 0);
    chk("arst_in_range", int'(in_range), 0);
    chk("arst_locked", int'(locked), 0);
    chk("arst_overflow", int'(overflow), 0);
    chk("arst_count_out2", int'(count_out2), 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    e2    = n;
    base  = n + 2;
    per   = 4;
    wait_pulse(at);
    chk("post_rst_pulse_time", at, e2 + 101);
    chk("post_rst_count", int'(count_out), 25);
    chk("post_rst_in_range", int'(in_range), 1);
    chk("post_rst_locked", int'(locked), 0);
    chk("post_rst_overflow", int'(overflow), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_gclk_freq_monitor
`default_nettype wire
